// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front ends: opcode encodings and the
// UART sequencer state encoding.
package alu_pkg;

    localparam logic [5:0] OP_ADD     = 6'b100000;
    localparam logic [5:0] OP_SUB     = 6'b100010;
    localparam logic [5:0] OP_AND     = 6'b100100;
    localparam logic [5:0] OP_OR      = 6'b100101;
    localparam logic [5:0] OP_XOR     = 6'b100110;
    localparam logic [5:0] OP_SRA     = 6'b000011;
    localparam logic [5:0] OP_SRL     = 6'b000010;
    localparam logic [5:0] OP_NOR     = 6'b100111;
    localparam logic [5:0] OP_DEFAULT = OP_ADD;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_B   = 3'd1,
        WAIT_OP  = 3'd2,
        EXEC     = 3'd3,
        SEND_RES = 3'd4,
        WAIT_RES = 3'd5,
        SEND_FLG = 3'd6,
        WAIT_FLG = 3'd7
    } state_t;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// Signal bundle between the UART/ALU environment (master) and the
// byte-stream sequencer (slave).
interface alu_uart_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_valid;
    logic [DATA_WIDTH-1:0] o_alu_a;
    logic [DATA_WIDTH-1:0] o_alu_b;
    logic [OP_WIDTH-1:0]   o_alu_op;
    logic [DATA_WIDTH-1:0] i_alu_result;
    logic [2:0]            i_alu_flags;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_start;
    logic                  i_tx_busy;
    logic                  i_tx_done;
    logic                  o_err;
    logic                  o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid, i_alu_result, i_alu_flags, i_tx_busy, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_err, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid, i_alu_result, i_alu_flags, i_tx_busy, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_err, o_busy
    );
endinterface

// File: rtl/alu_op_check.sv
// Opcode legality decode, shared by the UART sequencer and the switch front end.
module alu_op_check
    import alu_pkg::*;
(
    input  logic [5:0] op,
    output logic       legal
);
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, opcode bytes from the UART receiver, holds them on the ALU,
// then returns the result byte and a flags byte through the transmitter.
//
// state    | meaning
// IDLE     | waiting for operand A
// WAIT_B   | waiting for operand B (timeout armed)
// WAIT_OP  | waiting for opcode byte (timeout armed)
// EXEC     | ALU settle cycle
// SEND_RES | issue result byte once TX is free
// WAIT_RES | result byte in flight
// SEND_FLG | issue flags byte once TX is free
// WAIT_FLG | flags byte in flight
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    alu_uart_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] res_q, flg_q;
    logic                  op_legal;
    logic                  load_a, load_b, load_op, capture;
    logic                  start_n, err_n, sel_flags;

    alu_op_check u_op_check (
        .op    (bus.i_rx_data[5:0]),
        .legal (op_legal)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        capture   = 1'b0;
        start_n   = 1'b0;
        err_n     = 1'b0;
        sel_flags = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    load_a  = 1'b1;
                    state_n = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                // An arriving byte wins over an expiring timeout.
                if (bus.i_rx_valid) begin
                    if (state == WAIT_B) begin
                        load_b  = 1'b1;
                        state_n = WAIT_OP;
                    end else if (op_legal) begin
                        load_op = 1'b1;
                        state_n = EXEC;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_n = SEND_RES;
            end
            SEND_RES: begin
                if (!bus.i_tx_busy) begin
                    start_n = 1'b1;
                    state_n = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (bus.i_tx_done) state_n = SEND_FLG;
            end
            SEND_FLG: begin
                sel_flags = 1'b1;
                if (!bus.i_tx_busy) begin
                    start_n = 1'b1;
                    state_n = WAIT_FLG;
                end
            end
            WAIT_FLG: begin
                if (bus.i_tx_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_alu_a    <= '0;
            bus.o_alu_b    <= '0;
            bus.o_alu_op   <= OP_WIDTH'(OP_DEFAULT);
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_err      <= 1'b0;
            res_q          <= '0;
            flg_q          <= '0;
        end else begin
            bus.o_tx_start <= start_n;
            bus.o_err      <= err_n;
            if (load_a)  bus.o_alu_a  <= bus.i_rx_data;
            if (load_b)  bus.o_alu_b  <= bus.i_rx_data;
            if (load_op) bus.o_alu_op <= OP_WIDTH'(bus.i_rx_data[5:0]);
            if (capture) begin
                res_q <= bus.i_alu_result;
                flg_q <= {{(DATA_WIDTH-3){1'b0}}, bus.i_alu_flags};
            end
            if (start_n) bus.o_tx_data <= sel_flags ? flg_q : res_q;
        end
    end

    assign bus.o_busy = (state != IDLE);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: a behavioural ALU and UART transmitter
// surround the DUT; expected TX bytes and error pulses go through a scoreboard.
module tb_alu_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       tx_busy_m = 1'b0;
    logic       hold_busy = 1'b0;
    logic       tx_done = 1'b0;
    int         tx_left = 0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         t_last = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at_cycle;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_uart_ctrl_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();

    alu_uart_ctrl #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_CYCLES(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign bus.i_rx_data  = rx_data;
    assign bus.i_rx_valid = rx_valid;
    assign bus.i_tx_busy  = tx_busy_m | hold_busy;
    assign bus.i_tx_done  = tx_done;

    // Reference ALU: flags = {negative, zero, carry}; SUB carry is the borrow.
    logic [8:0] alu_w;
    always_comb begin
        alu_w = '0;
        case (bus.o_alu_op)
            6'b100000: alu_w = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
            6'b100010: alu_w = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
            6'b100100: alu_w = {1'b0, bus.o_alu_a & bus.o_alu_b};
            6'b100101: alu_w = {1'b0, bus.o_alu_a | bus.o_alu_b};
            6'b100110: alu_w = {1'b0, bus.o_alu_a ^ bus.o_alu_b};
            6'b100111: alu_w = {1'b0, ~(bus.o_alu_a | bus.o_alu_b)};
            6'b000010: alu_w = {1'b0, bus.o_alu_a >> bus.o_alu_b[2:0]};
            6'b000011: alu_w = {1'b0, 8'($signed(bus.o_alu_a) >>> bus.o_alu_b[2:0])};
            default:   alu_w = '0;
        endcase
    end
    assign bus.i_alu_result = alu_w[7:0];
    assign bus.i_alu_flags  = {alu_w[7], alu_w[7:0] == 8'h00, alu_w[8]};

    // Transmitter model: busy for six cycles after each start, then a done pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (bus.o_tx_start === 1'b1) begin
                tx_busy_m = 1'b1;
                tx_left   = 6;
            end else if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) begin
                    tx_busy_m = 1'b0;
                    tx_done   = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1 || bus.o_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: start=%0b err=%0b data=0x%02h, required no output (cycle %0d)",
                         bus.o_tx_start, bus.o_err, bus.o_tx_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_is_err", {31'd0, bus.o_err}, {31'd0, mon_e.is_err});
                if (!mon_e.is_err) chk("tx_data", {24'd0, bus.o_tx_data}, {24'd0, mon_e.data});
                if (mon_e.at_cycle >= 0) chk("out_cycle", cyc, mon_e.at_cycle);
            end
        end
    end

    task automatic push_tx(input logic [7:0] d, input int at);
        exp_q.push_back('{is_err: 1'b0, data: d, at_cycle: at});
    endtask

    task automatic push_err(input int at);
        exp_q.push_back('{is_err: 1'b1, data: 8'h00, at_cycle: at});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        t_last   = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (!bus.o_busy && !tx_busy_m) ok = 1'b1;
        end
        chk("idle_reached", {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        idle_cycles(1);
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_tx_start === 1'b1) ok = 1'b1;
        end
        chk("start_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_alu_a",    {24'd0, bus.o_alu_a},    32'h00);
        chk("rst_alu_b",    {24'd0, bus.o_alu_b},    32'h00);
        chk("rst_alu_op",   {26'd0, bus.o_alu_op},   32'h20);
        chk("rst_tx_data",  {24'd0, bus.o_tx_data},  32'h00);
        chk("rst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
        chk("rst_err",      {31'd0, bus.o_err},      32'd0);
        chk("rst_busy",     {31'd0, bus.o_busy},     32'd0);
    endtask

    initial begin
        idle_cycles(3);
        chk_reset_vals();
        rst_n = 1'b1;
        idle_cycles(2);

        // ADD 5+3; first start lands two edges after the edge that took the opcode.
        send_cmd(8'h05, 8'h03, 8'h20);
        push_tx(8'h08, t_last + 2);
        push_tx(8'h00, -1);
        wait_idle();
        chk("hold_alu_a",  {24'd0, bus.o_alu_a},  32'h05);
        chk("hold_alu_b",  {24'd0, bus.o_alu_b},  32'h03);
        chk("hold_alu_op", {26'd0, bus.o_alu_op}, 32'h20);

        // ADD overflow: result 0, zero and carry set.
        send_cmd(8'hFF, 8'h01, 8'h20);
        push_tx(8'h00, t_last + 2);
        push_tx(8'h03, -1);
        wait_idle();

        // Illegal opcode: error pulse on the next edge, opcode unchanged.
        send_cmd(8'h0A, 8'h0B, 8'h3F);
        push_err(t_last);
        wait_idle();
        chk("illegal_op_kept", {26'd0, bus.o_alu_op}, 32'h20);
        chk("illegal_a_new",   {24'd0, bus.o_alu_a},  32'h0A);
        chk("illegal_b_new",   {24'd0, bus.o_alu_b},  32'h0B);
        send_cmd(8'h0A, 8'h0B, 8'h20);
        push_tx(8'h15, t_last + 2);
        push_tx(8'h00, -1);
        wait_idle();

        // Timeout after a lone A byte (16-cycle limit).
        send_byte(8'h11);
        push_err(t_last + 16);
        idle_cycles(22);
        chk("timeout_idle", {31'd0, bus.o_busy}, 32'd0);
        chk("timeout_a",    {24'd0, bus.o_alu_a}, 32'h11);
        chk("sb_timeout",   exp_q.size(), 32'd0);
        send_cmd(8'hF0, 8'h0F, 8'h24);
        push_tx(8'h00, t_last + 2);
        push_tx(8'h02, -1);
        wait_idle();

        // Backpressure: SUB 0x10-0x20 held off by TX busy, then dropped RX bytes.
        hold_busy = 1'b1;
        send_cmd(8'h10, 8'h20, 8'h22);
        idle_cycles(20);
        hold_busy = 1'b0;
        push_tx(8'hF0, cyc + 1);
        push_tx(8'h05, -1);
        wait_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_idle();
        chk("drop_alu_a", {24'd0, bus.o_alu_a}, 32'h10);
        send_cmd(8'h5A, 8'h0F, 8'h26);
        push_tx(8'h55, t_last + 2);
        push_tx(8'h00, -1);
        wait_idle();
        chk("xor_alu_op", {26'd0, bus.o_alu_op}, 32'h26);

        // Reset after A and B: everything back to reset values, no TX.
        send_byte(8'h33);
        send_byte(8'h44);
        rst_n = 1'b0;
        idle_cycles(1);
        chk_reset_vals();
        rst_n = 1'b1;
        idle_cycles(25);
        chk("rst_mid_idle", {31'd0, bus.o_busy}, 32'd0);

        // Reset while the result byte is in flight: flags byte never sent.
        send_cmd(8'h01, 8'h02, 8'h20);
        push_tx(8'h03, t_last + 2);
        wait_start();
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        wait_idle();
        idle_cycles(15);
        chk("rst_tx_idle", {31'd0, bus.o_busy}, 32'd0);
        chk("sb_final",    exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
